// File: rtl/mvau_weight_fetch_if.sv
// mvau_weight_fetch_if
// Groups the two buses of the weight fetcher:
//   - the read port of the weight memory (address out, registered data back)
//   - the weight word stream sent to the PE datapath (valid/ready)
// Modports:
//   master : the fetcher (drives wmem_addr, wt_data, wt_valid)
//   slave  : memory + datapath side (drives wmem_rdata, wt_ready)
interface mvau_weight_fetch_if #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_ADDR_BW = 4
);
  localparam int WW = SIMD * TW;

  logic [WMEM_ADDR_BW-1:0] wmem_addr;
  logic [WW-1:0]           wmem_rdata;
  logic [WW-1:0]           wt_data;
  logic                    wt_valid;
  logic                    wt_ready;

  modport master (
    output wmem_addr,
    input  wmem_rdata,
    output wt_data,
    output wt_valid,
    input  wt_ready
  );

  modport slave (
    input  wmem_addr,
    output wmem_rdata,
    input  wt_data,
    input  wt_valid,
    output wt_ready
  );
endinterface

// File: rtl/mvau_weight_fetch.sv
// mvau_weight_fetch
// Read controller for one MVAU weight memory bank. On start it walks the
// memory addresses 0..WMEM_DEPTH-1, NUM_REPS times. It hides the memory's
// one-cycle registered read latency behind a small output FIFO, and it
// streams the words to the PE datapath with full backpressure.
// Ports:
//   aclk  : clock
//   rst   : synchronous, active-high reset; aborts any job in progress
//   start : begins a job; only looked at while idle
//   busy  : a job is in progress
//   done  : one-cycle pulse on the last output handshake of a job
//   bus   : master side of mvau_weight_fetch_if (memory read port + weight stream)
module mvau_weight_fetch #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4,
  parameter int NUM_REPS     = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic aclk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  mvau_weight_fetch_if.master bus
);

  localparam int WW     = SIMD * TW;
  localparam int PTR_BW = $clog2(FIFO_DEPTH);
  localparam int OCC_BW = PTR_BW + 1;
  localparam int CRD_BW = OCC_BW + 1;
  localparam int REP_BW = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q;
  logic [WMEM_ADDR_BW-1:0] addr_q;
  logic [WMEM_ADDR_BW-1:0] wmemAddr_q;
  logic [REP_BW-1:0]       rep_q;
  logic                    stage1_q;
  logic                    stage2_q;
  logic [WW-1:0]           fifoMem_q [FIFO_DEPTH];
  logic [PTR_BW-1:0]       wrPtr_q;
  logic [PTR_BW-1:0]       rdPtr_q;
  logic [OCC_BW-1:0]       occ_q;
  logic [OCC_BW-1:0]       occ_d;

  logic [CRD_BW-1:0] credit;
  logic              issue;
  logic              push;
  logic              pop;
  logic              lastAddr;
  logic              lastRep;
  logic              finalPop;

  // Credits count FIFO entries plus reads still travelling through the
  // issue->capture pipe. A read is issued only if its word is certain to
  // find a free FIFO slot, so the FIFO can never overflow.
  always_comb begin
    credit   = CRD_BW'(occ_q) + CRD_BW'(stage1_q) + CRD_BW'(stage2_q);
    issue    = (state_q == RUN) && (credit < CRD_BW'(FIFO_DEPTH));
    push     = stage2_q;
    pop      = (occ_q != '0) && bus.wt_ready;
    lastAddr = (addr_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1));
    lastRep  = (rep_q == REP_BW'(NUM_REPS - 1));
    // Once every read has been issued, the final word is the one that
    // leaves a FIFO with a single entry and nothing still in flight.
    finalPop = (state_q == DRAIN) && pop && (occ_q == OCC_BW'(1))
               && !stage1_q && !stage2_q;
    occ_d    = occ_q + OCC_BW'(push) - OCC_BW'(pop);
  end

  assign busy         = (state_q != IDLE);
  assign done         = finalPop;
  assign bus.wmem_addr = wmemAddr_q;
  assign bus.wt_valid  = (occ_q != '0);
  assign bus.wt_data   = fifoMem_q[rdPtr_q];

  // Job FSM plus address/repetition counters and the 2-stage tag pipe.
  // The tag in stage 2 marks the cycle whose wmem_rdata belongs to an
  // issued read, so it is written into the FIFO at the following edge.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rep_q      <= '0;
      wmemAddr_q <= '0;
      stage1_q   <= 1'b0;
      stage2_q   <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      occ_q      <= '0;
    end else begin
      stage1_q <= issue;
      stage2_q <= stage1_q;
      occ_q    <= occ_d;
      if (push) wrPtr_q <= wrPtr_q + PTR_BW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_BW'(1);

      if (issue) begin
        wmemAddr_q <= addr_q;
        if (lastAddr) begin
          addr_q <= '0;
          rep_q  <= lastRep ? '0 : rep_q + REP_BW'(1);
        end else begin
          addr_q <= addr_q + WMEM_ADDR_BW'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            addr_q  <= '0;
            rep_q   <= '0;
          end
        end
        RUN: begin
          if (issue && lastAddr && lastRep) state_q <= DRAIN;
        end
        DRAIN: begin
          if (finalPop) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO storage is cleared on reset so the head word reads as zero.
  always_ff @(posedge aclk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifoMem_q[i] <= '0;
    end else if (push) begin
      fifoMem_q[wrPtr_q] <= bus.wmem_rdata;
    end
  end

endmodule

// File: tb/tb_mvau_weight_fetch.sv
// tb_mvau_weight_fetch
// Directed bench for mvau_weight_fetch. A behavioural memory with a
// one-cycle registered read holds mem[i] = i+1. Each scenario task drives
// one job and compares what it observed with hand-derived values.
module tb_mvau_weight_fetch;

  localparam int SIMD       = 4;
  localparam int TW         = 2;
  localparam int W          = SIMD * TW;
  localparam int DEPTH      = 4;
  localparam int ABW        = 4;
  localparam int REPS       = 2;
  localparam int FDEPTH     = 4;
  localparam int NWORDS     = DEPTH * REPS;
  localparam int MAXCYC     = 400;

  logic aclk;
  logic rst;
  logic start;
  logic busy;
  logic done;

  mvau_weight_fetch_if #(.SIMD(SIMD), .TW(TW), .WMEM_ADDR_BW(ABW)) bus ();

  mvau_weight_fetch #(
    .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW),
    .NUM_REPS(REPS), .FIFO_DEPTH(FDEPTH)
  ) dut (
    .aclk (aclk),
    .rst  (rst),
    .start(start),
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  // Clock: 10 time-unit period.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Weight memory model: one-cycle registered read.
  logic [W-1:0] memModel [2**ABW];
  initial begin
    for (int i = 0; i < 2**ABW; i++) memModel[i] = W'(i + 1);
  end
  always @(posedge aclk) bus.wmem_rdata <= memModel[bus.wmem_addr];

  int nChecks = 0;
  int nFails  = 0;

  // Results gathered by runJob.
  logic [W-1:0] gotWords [$];
  int           doneCount;
  int           doneAtWord;
  int           firstValid;
  int           validGaps;
  int           stallErrs;
  logic         busyAfterDone;
  logic [ABW-1:0] stallAddr;
  bit           timedOut;

  logic [W-1:0] expWord;
  logic [W-1:0] gotWord;

  // Runs cycles until one cycle after done (or a cycle budget expires),
  // driving wt_ready per mode: 0 = always ready, 1 = stalled in cycles
  // 3..8 after the start edge, 2 = ready about 30% of the time.
  // Cycle 0 is the first falling edge after the start edge.
  task automatic runJob(input int mode, input bit doStart, input int midStart,
                        input bit startOnDone);
    bit           finished;
    bit           prevStall;
    logic [W-1:0] prevData;
    gotWords.delete();
    doneCount     = 0;
    doneAtWord    = -1;
    firstValid    = -1;
    validGaps     = 0;
    stallErrs     = 0;
    busyAfterDone = 1'bx;
    stallAddr     = 'x;
    timedOut      = 1'b0;
    finished      = 1'b0;
    prevStall     = 1'b0;
    prevData      = '0;
    if (doStart) begin
      @(negedge aclk);
      start = 1'b1;
      bus.wt_ready = (mode != 2);
    end
    for (int cyc = 0; cyc < MAXCYC && !finished; cyc++) begin
      @(negedge aclk);
      if (doStart && cyc == 0) start = 1'b0;
      if (midStart >= 0) start = (cyc == midStart);
      case (mode)
        1:       bus.wt_ready = !(cyc >= 3 && cyc < 9);
        2:       bus.wt_ready = ($urandom_range(0, 99) < 30);
        default: bus.wt_ready = 1'b1;
      endcase
      #1;
      if (doneCount > 0) begin
        busyAfterDone = busy;
        finished = 1'b1;
      end else begin
        if (mode == 1 && cyc == 8) stallAddr = bus.wmem_addr;
        if (prevStall && (!bus.wt_valid || bus.wt_data !== prevData)) stallErrs++;
        if (bus.wt_valid && firstValid < 0) firstValid = cyc;
        if (!bus.wt_valid && firstValid >= 0) validGaps++;
        prevStall = bus.wt_valid && !bus.wt_ready;
        prevData  = bus.wt_data;
        if (bus.wt_valid && bus.wt_ready) gotWords.push_back(bus.wt_data);
        if (done) begin
          doneCount++;
          doneAtWord = gotWords.size();
          if (startOnDone) start = 1'b1;
        end
      end
    end
    if (!finished) timedOut = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    bus.wt_ready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    nChecks++; if (bus.wmem_addr !== '0) begin nFails++; $display("[TB] FAIL reset_wmem_addr: got %0h, expected 0", bus.wmem_addr); end
    nChecks++; if (bus.wt_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_wt_valid: got %b, expected 0", bus.wt_valid); end
    nChecks++; if (bus.wt_data !== '0) begin nFails++; $display("[TB] FAIL reset_wt_data: got %0h, expected 0", bus.wt_data); end
    rst = 1'b0;
  endtask

  task automatic test_ordered_stream;
    runJob(0, 1'b1, -1, 1'b0);
    nChecks++; if (timedOut) begin nFails++; $display("[TB] FAIL ordered_timeout: got timeout, expected done within %0d cycles", MAXCYC); end
    nChecks++; if (gotWords.size() != NWORDS) begin nFails++; $display("[TB] FAIL ordered_count: got %0d, expected %0d", gotWords.size(), NWORDS); end
    for (int i = 0; i < NWORDS; i++) begin
      expWord = W'(i % DEPTH + 1);
      gotWord = (i < gotWords.size()) ? gotWords[i] : 'x;
      nChecks++; if (gotWord !== expWord) begin nFails++; $display("[TB] FAIL ordered_word[%0d]: got %0h, expected %0h", i, gotWord, expWord); end
    end
    nChecks++; if (firstValid != 3) begin nFails++; $display("[TB] FAIL ordered_first_valid: got cycle %0d, expected 3", firstValid); end
    nChecks++; if (validGaps != 0) begin nFails++; $display("[TB] FAIL ordered_valid_gaps: got %0d, expected 0", validGaps); end
    nChecks++; if (doneCount != 1) begin nFails++; $display("[TB] FAIL ordered_done_count: got %0d, expected 1", doneCount); end
    nChecks++; if (doneAtWord != NWORDS) begin nFails++; $display("[TB] FAIL ordered_done_word: got %0d, expected %0d", doneAtWord, NWORDS); end
    nChecks++; if (busyAfterDone !== 1'b0) begin nFails++; $display("[TB] FAIL ordered_busy_after_done: got %b, expected 0", busyAfterDone); end
  endtask

  // Stalled from the first valid cycle: reads for addresses 0..3 fill the
  // four credits, so the last issued address (3) stays on wmem_addr.
  task automatic test_backpressure;
    runJob(1, 1'b1, -1, 1'b0);
    nChecks++; if (stallAddr !== ABW'(3)) begin nFails++; $display("[TB] FAIL bp_addr_frozen: got %0h, expected 3", stallAddr); end
    nChecks++; if (stallErrs != 0) begin nFails++; $display("[TB] FAIL bp_stall_stable: got %0d violations, expected 0", stallErrs); end
    nChecks++; if (gotWords.size() != NWORDS) begin nFails++; $display("[TB] FAIL bp_count: got %0d, expected %0d", gotWords.size(), NWORDS); end
    for (int i = 0; i < NWORDS; i++) begin
      expWord = W'(i % DEPTH + 1);
      gotWord = (i < gotWords.size()) ? gotWords[i] : 'x;
      nChecks++; if (gotWord !== expWord) begin nFails++; $display("[TB] FAIL bp_word[%0d]: got %0h, expected %0h", i, gotWord, expWord); end
    end
    nChecks++; if (validGaps != 0) begin nFails++; $display("[TB] FAIL bp_valid_gaps: got %0d, expected 0", validGaps); end
    nChecks++; if (doneAtWord != NWORDS) begin nFails++; $display("[TB] FAIL bp_done_word: got %0d, expected %0d", doneAtWord, NWORDS); end
  endtask

  task automatic test_random_ready;
    runJob(2, 1'b1, -1, 1'b0);
    nChecks++; if (timedOut) begin nFails++; $display("[TB] FAIL rnd_timeout: got timeout, expected done within %0d cycles", MAXCYC); end
    nChecks++; if (gotWords.size() != NWORDS) begin nFails++; $display("[TB] FAIL rnd_count: got %0d, expected %0d", gotWords.size(), NWORDS); end
    for (int i = 0; i < NWORDS; i++) begin
      expWord = W'(i % DEPTH + 1);
      gotWord = (i < gotWords.size()) ? gotWords[i] : 'x;
      nChecks++; if (gotWord !== expWord) begin nFails++; $display("[TB] FAIL rnd_word[%0d]: got %0h, expected %0h", i, gotWord, expWord); end
    end
    nChecks++; if (stallErrs != 0) begin nFails++; $display("[TB] FAIL rnd_stall_stable: got %0d violations, expected 0", stallErrs); end
    nChecks++; if (doneAtWord != NWORDS) begin nFails++; $display("[TB] FAIL rnd_done_word: got %0d, expected %0d", doneAtWord, NWORDS); end
  endtask

  task automatic test_start_while_busy;
    runJob(0, 1'b1, 6, 1'b0);
    nChecks++; if (gotWords.size() != NWORDS) begin nFails++; $display("[TB] FAIL swb_count: got %0d, expected %0d", gotWords.size(), NWORDS); end
    nChecks++; if (doneAtWord != NWORDS) begin nFails++; $display("[TB] FAIL swb_done_word: got %0d, expected %0d", doneAtWord, NWORDS); end
    repeat (4) @(negedge aclk);
    #1;
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL swb_idle_busy: got %b, expected 0", busy); end
    nChecks++; if (bus.wt_valid !== 1'b0) begin nFails++; $display("[TB] FAIL swb_idle_valid: got %b, expected 0", bus.wt_valid); end
  endtask

  task automatic test_reset_mid_run;
    int  hs;
    bit  sawDone;
    hs = 0;
    sawDone = 1'b0;
    @(negedge aclk);
    start = 1'b1;
    bus.wt_ready = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    for (int cyc = 0; cyc < MAXCYC && hs < 3; cyc++) begin
      #1;
      if (bus.wt_valid && bus.wt_ready) hs++;
      if (done) sawDone = 1'b1;
      if (hs < 3) @(negedge aclk);
    end
    nChecks++; if (hs != 3) begin nFails++; $display("[TB] FAIL rmr_handshakes: got %0d, expected 3", hs); end
    @(negedge aclk);
    rst = 1'b1;
    @(posedge aclk);
    #1;
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL rmr_busy: got %b, expected 0", busy); end
    nChecks++; if (bus.wt_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rmr_valid: got %b, expected 0", bus.wt_valid); end
    nChecks++; if (bus.wmem_addr !== '0) begin nFails++; $display("[TB] FAIL rmr_addr: got %0h, expected 0", bus.wmem_addr); end
    nChecks++; if (done !== 1'b0 || sawDone) begin nFails++; $display("[TB] FAIL rmr_no_done: got done=%b seen=%b, expected 0", done, sawDone); end
    @(negedge aclk);
    rst = 1'b0;
    runJob(0, 1'b1, -1, 1'b0);
    nChecks++; if (gotWords.size() != NWORDS) begin nFails++; $display("[TB] FAIL rmr_restart_count: got %0d, expected %0d", gotWords.size(), NWORDS); end
    for (int i = 0; i < NWORDS; i++) begin
      expWord = W'(i % DEPTH + 1);
      gotWord = (i < gotWords.size()) ? gotWords[i] : 'x;
      nChecks++; if (gotWord !== expWord) begin nFails++; $display("[TB] FAIL rmr_word[%0d]: got %0h, expected %0h", i, gotWord, expWord); end
    end
  endtask

  // start raised in the done cycle and held one more cycle: only the
  // second edge (state already IDLE) launches the next job.
  task automatic test_back_to_back;
    runJob(0, 1'b1, -1, 1'b1);
    nChecks++; if (doneAtWord != NWORDS) begin nFails++; $display("[TB] FAIL b2b_first_done_word: got %0d, expected %0d", doneAtWord, NWORDS); end
    nChecks++; if (busyAfterDone !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_busy_after_done: got %b, expected 0", busyAfterDone); end
    @(negedge aclk);
    start = 1'b0;
    #1;
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_second_busy: got %b, expected 1", busy); end
    runJob(0, 1'b0, -1, 1'b0);
    nChecks++; if (gotWords.size() != NWORDS) begin nFails++; $display("[TB] FAIL b2b_second_count: got %0d, expected %0d", gotWords.size(), NWORDS); end
    for (int i = 0; i < NWORDS; i++) begin
      expWord = W'(i % DEPTH + 1);
      gotWord = (i < gotWords.size()) ? gotWords[i] : 'x;
      nChecks++; if (gotWord !== expWord) begin nFails++; $display("[TB] FAIL b2b_word[%0d]: got %0h, expected %0h", i, gotWord, expWord); end
    end
    nChecks++; if (doneAtWord != NWORDS) begin nFails++; $display("[TB] FAIL b2b_second_done_word: got %0d, expected %0d", doneAtWord, NWORDS); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.wt_ready = 1'b0;
    test_reset();
    test_ordered_stream();
    test_backpressure();
    test_random_ready();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
